// File: rtl/adder_pkg.sv
// Shared constants for the switch-adder operand sequencer.
package adder_pkg;

  localparam logic [1:0] ST_EMPTY = 2'b00;
  localparam logic [1:0] ST_ACC   = 2'b01;
  localparam logic [1:0] ST_DONE  = 2'b10;

  // 1 ms of stable input at 16 MHz
  localparam int unsigned DB_CYCLES_DEFAULT = 16000;

endpackage

// File: rtl/adder_sequencer_if.sv
// Board-side bundle of the sequencer: raw switch/button inputs and display outputs.
interface adder_sequencer_if #(
  parameter int unsigned IN_W  = 4,
  parameter int unsigned SUM_W = 8
);

  logic [IN_W-1:0]  switches;
  logic             exec_btn;
  logic             clr_btn;
  logic [SUM_W-1:0] sum;
  logic [1:0]       state;
  logic [3:0]       op_cnt;
  logic             carry;
  logic             led;

  modport master (
    output switches, exec_btn, clr_btn,
    input  sum, state, op_cnt, carry, led
  );

  modport slave (
    input  switches, exec_btn, clr_btn,
    output sum, state, op_cnt, carry, led
  );

endinterface

// File: rtl/adder_sequencer_btn_debounce.sv
// Button conditioner: 2-flop synchronizer, stability-count debounce and
// a one-cycle pulse on each rising edge of the debounced level.
module btn_debounce
  import adder_pkg::*;
#(
  parameter int unsigned DB_CYCLES = DB_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic rise_p
);

  localparam int unsigned CNT_W = $clog2(DB_CYCLES);

  logic             meta_r;
  logic             sync_r;
  logic             level_r;
  logic             level_d_r;
  logic             rise_r;
  logic [CNT_W-1:0] cnt_r;

  // Synchronize, debounce against the current level, register the rising edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_r    <= 1'b0;
      sync_r    <= 1'b0;
      level_r   <= 1'b0;
      level_d_r <= 1'b0;
      rise_r    <= 1'b0;
      cnt_r     <= '0;
    end else begin
      meta_r    <= raw;
      sync_r    <= meta_r;
      level_d_r <= level_r;
      rise_r    <= level_r & ~level_d_r;
      // any sample matching the current level restarts the stability count
      if (sync_r == level_r) begin
        cnt_r <= '0;
      end else if (cnt_r == CNT_W'(DB_CYCLES - 1)) begin
        level_r <= sync_r;
        cnt_r   <= '0;
      end else begin
        cnt_r <= cnt_r + CNT_W'(1);
      end
    end
  end

  assign level  = level_r;
  assign rise_p = rise_r;

endmodule

// File: rtl/adder_sequencer.sv
// Clocked operand sequencer: debounced EXEC/CLR drive a load/accumulate FSM
// that builds a running sum of the switch bank for the segment decoders.
module adder_sequencer
  import adder_pkg::*;
#(
  parameter int unsigned IN_W      = 4,
  parameter int unsigned SUM_W     = 8,
  parameter int unsigned MAX_OPS   = 2,
  parameter int unsigned DB_CYCLES = DB_CYCLES_DEFAULT
) (
  input  logic           clk,
  input  logic           rst,
  adder_sequencer_if.slave bus
);

  logic             exec_p_s;
  logic             clr_p_s;
  logic             exec_level_unused;
  logic             clr_level_unused;

  logic [IN_W-1:0]  sw_meta_r;
  logic [IN_W-1:0]  sw_sync_r;

  logic [1:0]       state_r;
  logic [1:0]       state_s;
  logic [SUM_W-1:0] sum_r;
  logic [SUM_W-1:0] sum_s;
  logic [3:0]       op_cnt_r;
  logic [3:0]       op_cnt_s;
  logic             carry_r;
  logic             carry_s;
  logic [SUM_W:0]   add_s;
  logic [SUM_W:0]   load_s;
  logic             last_op_s;

  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_exec_db (
    .clk    (clk),
    .rst    (rst),
    .raw    (bus.exec_btn),
    .level  (exec_level_unused),
    .rise_p (exec_p_s)
  );

  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_clr_db (
    .clk    (clk),
    .rst    (rst),
    .raw    (bus.clr_btn),
    .level  (clr_level_unused),
    .rise_p (clr_p_s)
  );

  // Two-flop synchronizer for the switch bank
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sw_meta_r <= '0;
      sw_sync_r <= '0;
    end else begin
      sw_meta_r <= bus.switches;
      sw_sync_r <= sw_meta_r;
    end
  end

  assign load_s    = (SUM_W + 1)'(sw_sync_r);
  assign add_s     = {1'b0, sum_r} + load_s;
  assign last_op_s = ((32'(op_cnt_r) + 32'd1) == MAX_OPS);

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_EMPTY;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic; clear has priority over exec
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_EMPTY, ST_DONE: begin
        if (clr_p_s) begin
          state_s = ST_EMPTY;
        end else if (exec_p_s) begin
          state_s = (MAX_OPS == 32'd1) ? ST_DONE : ST_ACC;
        end else begin
          state_s = state_r;
        end
      end
      ST_ACC: begin
        if (clr_p_s) begin
          state_s = ST_EMPTY;
        end else if (exec_p_s) begin
          state_s = last_op_s ? ST_DONE : ST_ACC;
        end else begin
          state_s = state_r;
        end
      end
      default: state_s = ST_EMPTY;
    endcase
  end

  // Accumulator next values; an illegal state code behaves as a clear
  always_comb begin
    sum_s    = sum_r;
    op_cnt_s = op_cnt_r;
    carry_s  = carry_r;
    if (clr_p_s || (state_r == 2'b11)) begin
      sum_s    = '0;
      op_cnt_s = 4'd0;
      carry_s  = 1'b0;
    end else if (exec_p_s) begin
      case (state_r)
        ST_ACC: begin
          sum_s    = add_s[SUM_W-1:0];
          op_cnt_s = op_cnt_r + 4'd1;
          carry_s  = carry_r | add_s[SUM_W];
        end
        default: begin
          sum_s    = load_s[SUM_W-1:0];
          op_cnt_s = 4'd1;
          carry_s  = 1'b0;
        end
      endcase
    end else begin
      sum_s    = sum_r;
      op_cnt_s = op_cnt_r;
      carry_s  = carry_r;
    end
  end

  // Accumulator registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_r    <= '0;
      op_cnt_r <= 4'd0;
      carry_r  <= 1'b0;
    end else begin
      sum_r    <= sum_s;
      op_cnt_r <= op_cnt_s;
      carry_r  <= carry_s;
    end
  end

  assign bus.sum    = sum_r;
  assign bus.state  = state_r;
  assign bus.op_cnt = op_cnt_r;
  assign bus.carry  = carry_r;
  assign bus.led    = state_r[0];

endmodule

// File: tb/tb_adder_sequencer.sv
// Scoreboard bench: three sequencers (MAX_OPS 2, 15, 20) with a short debounce.
module tb_adder_sequencer;
  import adder_pkg::*;

  localparam int DB = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] sw = 4'h0;
  logic [2:0] exec_raw = 3'b000;
  logic [2:0] clr_raw = 3'b000;

  always #5 clk = ~clk;

  adder_sequencer_if #(.IN_W(4), .SUM_W(8)) bus0 ();
  adder_sequencer_if #(.IN_W(4), .SUM_W(8)) bus1 ();
  adder_sequencer_if #(.IN_W(4), .SUM_W(8)) bus2 ();

  assign bus0.switches = sw;
  assign bus0.exec_btn = exec_raw[0];
  assign bus0.clr_btn  = clr_raw[0];
  assign bus1.switches = sw;
  assign bus1.exec_btn = exec_raw[1];
  assign bus1.clr_btn  = clr_raw[1];
  assign bus2.switches = sw;
  assign bus2.exec_btn = exec_raw[2];
  assign bus2.clr_btn  = clr_raw[2];

  adder_sequencer #(.IN_W(4), .SUM_W(8), .MAX_OPS(2), .DB_CYCLES(DB)) dut0 (
    .clk(clk), .rst(rst), .bus(bus0)
  );
  adder_sequencer #(.IN_W(4), .SUM_W(8), .MAX_OPS(15), .DB_CYCLES(DB)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1)
  );
  adder_sequencer #(.IN_W(4), .SUM_W(8), .MAX_OPS(20), .DB_CYCLES(DB)) dut2 (
    .clk(clk), .rst(rst), .bus(bus2)
  );

  // observed tuple: {sum, state, op_cnt, carry, led}
  logic [15:0] obs [3];
  assign obs[0] = {bus0.sum, bus0.state, bus0.op_cnt, bus0.carry, bus0.led};
  assign obs[1] = {bus1.sum, bus1.state, bus1.op_cnt, bus1.carry, bus1.led};
  assign obs[2] = {bus2.sum, bus2.state, bus2.op_cnt, bus2.carry, bus2.led};

  logic [15:0] exp_q [3][$];
  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int lat_ref = 0;
  int lat_req = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] tup(input logic [7:0] s, input logic [1:0] st,
                                      input logic [3:0] n, input logic c);
    return {s, st, n, c, st[0]};
  endfunction

  // Monitor: every output change pops one expectation; reset values checked while rst is high
  initial begin : monitor
    logic [15:0] prev [3];
    int          age [3];
    logic [15:0] e;
    int          lat;
    int          lat_done;
    lat_done = 0;
    for (int i = 0; i < 3; i++) begin
      prev[i] = 16'h0000;
      age[i]  = 0;
    end
    forever begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        if (rst) begin
          vectors++;
          if (obs[i] !== 16'h0000) begin
            miscompares++;
            $display("FAIL reset dut%0d: got %h required 0000", i, obs[i]);
          end
          prev[i] = obs[i];
          age[i]  = 0;
        end else if (obs[i] !== prev[i]) begin
          prev[i] = obs[i];
          age[i]  = 0;
          vectors++;
          if (exp_q[i].size() == 0) begin
            miscompares++;
            $display("FAIL spurious dut%0d: got %h with no event expected", i, obs[i]);
          end else begin
            e = exp_q[i].pop_front();
            if (obs[i] !== e) begin
              miscompares++;
              $display("FAIL result dut%0d: got %h required %h", i, obs[i], e);
            end
          end
          if (i == 0 && lat_req != lat_done) begin
            lat_done = lat_req;
            lat = cyc - 1 - lat_ref;
            vectors++;
            if (lat < DB + 2 || lat > DB + 4) begin
              miscompares++;
              $display("FAIL latency dut0: got %0d cycles required %0d..%0d", lat, DB + 2, DB + 4);
            end
          end
        end else if (exp_q[i].size() != 0) begin
          age[i]++;
          if (age[i] > 60) begin
            vectors++;
            miscompares++;
            $display("FAIL timeout dut%0d: got no update required %h", i, exp_q[i][0]);
            exp_q[i].delete();
            age[i] = 0;
          end
        end
      end
    end
  end

  task automatic press(input int i, input logic [3:0] v, input logic [15:0] e);
    sw = v;
    repeat (3) @(negedge clk);
    exp_q[i].push_back(e);
    exec_raw[i] = 1'b1;
    repeat (8) @(negedge clk);
    exec_raw[i] = 1'b0;
    repeat (12) @(negedge clk);
  endtask

  task automatic press_clr(input int i, input logic [15:0] e);
    exp_q[i].push_back(e);
    clr_raw[i] = 1'b1;
    repeat (8) @(negedge clk);
    clr_raw[i] = 1'b0;
    repeat (12) @(negedge clk);
  endtask

  initial begin : stimulus
    int hi [4];
    int lo [4];
    logic [8:0] s;
    logic       c;
    hi = '{1, 3, 2, 3};
    lo = '{1, 2, 1, 1};

    // reset held with switches high and buttons toggling
    sw = 4'hF;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      exec_raw = ~exec_raw;
      clr_raw  = ~clr_raw;
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    exec_raw = 3'b000;
    clr_raw  = 3'b000;
    repeat (12) @(negedge clk);

    // load then accumulate to DONE
    press(0, 4'h9, tup(8'h09, ST_ACC, 4'd1, 1'b0));
    press(0, 4'h7, tup(8'h10, ST_DONE, 4'd2, 1'b0));

    // chatter then a clean hold: one operand, restart from DONE
    sw = 4'h3;
    repeat (3) @(negedge clk);
    exp_q[0].push_back(tup(8'h03, ST_ACC, 4'd1, 1'b0));
    for (int k = 0; k < 4; k++) begin
      exec_raw[0] = 1'b1;
      repeat (hi[k]) @(negedge clk);
      exec_raw[0] = 1'b0;
      repeat (lo[k]) @(negedge clk);
    end
    lat_ref = cyc;
    lat_req = lat_req + 1;
    exec_raw[0] = 1'b1;
    repeat (10) @(negedge clk);
    exec_raw[0] = 1'b0;
    repeat (14) @(negedge clk);

    press(0, 4'h9, tup(8'h0C, ST_DONE, 4'd2, 1'b0));
    press(0, 4'hC, tup(8'h0C, ST_ACC, 4'd1, 1'b0));

    // exec and clear pulses in the same cycle: clear wins
    exp_q[0].push_back(tup(8'h00, ST_EMPTY, 4'd0, 1'b0));
    exec_raw[0] = 1'b1;
    clr_raw[0]  = 1'b1;
    repeat (8) @(negedge clk);
    exec_raw[0] = 1'b0;
    clr_raw[0]  = 1'b0;
    repeat (12) @(negedge clk);

    press(0, 4'hF, tup(8'h0F, ST_ACC, 4'd1, 1'b0));
    press(0, 4'hF, tup(8'h1E, ST_DONE, 4'd2, 1'b0));
    press_clr(0, tup(8'h00, ST_EMPTY, 4'd0, 1'b0));

    // fifteen operands of F, no wrap
    s = 9'd0;
    for (int n = 1; n <= 15; n++) begin
      s = s + 9'd15;
      press(1, 4'hF, tup(s[7:0], (n == 15) ? ST_DONE : ST_ACC, 4'(n), 1'b0));
    end

    // eighteen operands of F with MAX_OPS beyond reach: wraps and sets carry
    s = 9'd0;
    c = 1'b0;
    for (int n = 1; n <= 18; n++) begin
      s = {1'b0, s[7:0]} + 9'd15;
      c = c | s[8];
      press(2, 4'hF, tup(s[7:0], ST_ACC, 4'(n), c));
    end

    // reset during a pending press discards it
    press(0, 4'h5, tup(8'h05, ST_ACC, 4'd1, 1'b0));
    sw = 4'h6;
    exec_raw[0] = 1'b1;
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    exec_raw[0] = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (30) @(negedge clk);

    repeat (70) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
